// File: rtl/rtmq_gate_seq_pkg.sv
// rtmq_gate_seq_pkg: state encoding and default sizing for the gate sequencer
package rtmq_gate_seq_pkg;
    localparam int N_CTR_DEF   = 8;
    localparam int W_TIM_DEF   = 32;
    localparam int W_REP_DEF   = 16;
    localparam int SMP_LAT_DEF = 3;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_GATE   = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;
endpackage

// File: rtl/rtmq_tick_timer.sv
// rtmq_tick_timer: loadable down-counter that expires when the count reaches 1
module rtmq_tick_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         expire
);
    logic [W-1:0] cnt;
    assign expire = cnt == W'(1);
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && !expire && cnt != '0)
            cnt <= cnt - W'(1);
    end
endmodule

// File: rtl/rtmq_gate_sequencer.sv
// rtmq_gate_sequencer: issues N gate windows with settle, result handshake and gap
module rtmq_gate_sequencer
    import rtmq_gate_seq_pkg::*;
#(
    parameter int N_CTR   = N_CTR_DEF,
    parameter int W_TIM   = W_TIM_DEF,
    parameter int W_REP   = W_REP_DEF,
    parameter int SMP_LAT = SMP_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CTR-1:0] cfg_mask,
    input  logic [W_TIM-1:0] cfg_gate,
    input  logic [W_TIM-1:0] cfg_gap,
    input  logic [W_REP-1:0] cfg_nrep,
    input  logic             start,
    input  logic             abort,
    input  logic             res_rdy,
    output logic [N_CTR-1:0] gate_ena,
    output logic             busy,
    output logic             res_vld,
    output logic [W_REP-1:0] res_idx,
    output logic             done
);
    logic [2:0]       state_q, nxt;
    logic [N_CTR-1:0] mask_q, mask_d;
    logic [W_TIM-1:0] gate_q, gap_q, gate_in, tval;
    logic [W_REP-1:0] nrep_q, idx_d;
    logic             take, tload, expire, done_d, last;

    assign gate_in = cfg_gate == '0 ? W_TIM'(1) : cfg_gate;
    assign mask_d  = take ? cfg_mask : mask_q;
    assign last    = res_idx == nrep_q - W_REP'(1);

    rtmq_tick_timer #(.W(W_TIM)) u_timer (
        .clk(clk),
        .rst(rst),
        .load(tload),
        .en(state_q != ST_IDLE),
        .load_val(tval),
        .expire(expire)
    );

    always_comb begin
        nxt    = state_q;
        take   = 1'b0;
        tload  = 1'b0;
        tval   = gate_q;
        done_d = 1'b0;
        idx_d  = res_idx;
        case (state_q)
            ST_IDLE: if (start && !abort) begin
                take = 1'b1;
                if (cfg_nrep == '0) begin
                    done_d = 1'b1;
                end else begin
                    nxt   = ST_GATE;
                    tload = 1'b1;
                    tval  = gate_in;
                    idx_d = '0;
                end
            end
            ST_GATE: if (expire) begin
                nxt   = ST_SETTLE;
                tload = 1'b1;
                tval  = W_TIM'(SMP_LAT);
            end
            ST_SETTLE: nxt = expire ? ST_HOLD : ST_SETTLE;
            ST_HOLD: if (res_rdy) begin
                if (last) begin
                    nxt    = ST_IDLE;
                    done_d = 1'b1;
                end else begin
                    // a zero gap skips GAP so the next gate opens right after the handshake
                    nxt   = gap_q == '0 ? ST_GATE : ST_GAP;
                    tload = 1'b1;
                    tval  = gap_q == '0 ? gate_q : gap_q;
                    idx_d = res_idx + W_REP'(1);
                end
            end
            ST_GAP: if (expire) begin
                nxt   = ST_GATE;
                tload = 1'b1;
            end
            default: nxt = ST_IDLE;
        endcase
        if (abort && state_q != ST_IDLE) begin
            nxt    = ST_IDLE;
            tload  = 1'b0;
            done_d = 1'b0;
            idx_d  = res_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mask_q   <= '0;
            gate_q   <= '0;
            gap_q    <= '0;
            nrep_q   <= '0;
            gate_ena <= '0;
            busy     <= 1'b0;
            res_vld  <= 1'b0;
            res_idx  <= '0;
            done     <= 1'b0;
        end else begin
            state_q  <= nxt;
            mask_q   <= mask_d;
            gate_q   <= take ? gate_in : gate_q;
            gap_q    <= take ? cfg_gap : gap_q;
            nrep_q   <= take ? cfg_nrep : nrep_q;
            gate_ena <= nxt == ST_GATE ? mask_d : '0;
            busy     <= nxt != ST_IDLE;
            res_vld  <= nxt == ST_HOLD;
            res_idx  <= idx_d;
            done     <= done_d;
        end
    end
endmodule

// File: tb/tb_rtmq_gate_sequencer.sv
// tb_rtmq_gate_sequencer: directed scenario tests for the gate sequencer
module tb_rtmq_gate_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  cfg_mask = '0;
    logic [31:0] cfg_gate = '0;
    logic [31:0] cfg_gap = '0;
    logic [15:0] cfg_nrep = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        res_rdy = 1'b1;
    logic [7:0]  gate_ena;
    logic        busy;
    logic        res_vld;
    logic [15:0] res_idx;
    logic        done;
    int errs = 0;
    int checks = 0;

    rtmq_gate_sequencer dut (
        .clk(clk), .rst(rst), .cfg_mask(cfg_mask), .cfg_gate(cfg_gate), .cfg_gap(cfg_gap),
        .cfg_nrep(cfg_nrep), .start(start), .abort(abort), .res_rdy(res_rdy),
        .gate_ena(gate_ena), .busy(busy), .res_vld(res_vld), .res_idx(res_idx), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({gate_ena, busy, res_vld, res_idx, done} !== 27'd0) begin
            errs++;
            $display("FAIL reset gate=%h busy=%b vld=%b idx=%0d done=%b, want all 0", gate_ena, busy, res_vld, res_idx, done);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int nb;
        logic [7:0] eg;
        logic ev;
        logic [15:0] ei;
        nb = 0;
        cfg_mask = 8'h05; cfg_gate = 4; cfg_gap = 2; cfg_nrep = 3; res_rdy = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < (r < 2 ? 10 : 8); c++) begin
                eg = c < 4 ? 8'h05 : 8'h00;
                ev = c == 7;
                ei = c < 8 ? 16'(r) : 16'(r + 1);
                checks++;
                if (gate_ena !== eg || res_vld !== ev || res_idx !== ei || busy !== 1'b1 || done !== 1'b0) begin
                    errs++;
                    $display("FAIL basic r%0d c%0d gate=%h vld=%b idx=%0d busy=%b done=%b, want gate=%h vld=%b idx=%0d busy=1 done=0",
                             r, c, gate_ena, res_vld, res_idx, busy, done, eg, ev, ei);
                end
                nb += int'(busy);
                tick();
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || res_vld !== 1'b0) begin
            errs++;
            $display("FAIL basic_done done=%b busy=%b vld=%b, want 1 0 0", done, busy, res_vld);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin errs++; $display("FAIL basic_done_pulse done=%b, want 0", done); end
        checks++;
        if (nb != 28) begin errs++; $display("FAIL basic_busy_cycles got %0d, want 28", nb); end
    endtask

    task automatic test_back_pressure();
        cfg_mask = 8'h05; cfg_gate = 4; cfg_gap = 2; cfg_nrep = 3; res_rdy = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        repeat (10) tick();
        res_rdy = 1'b0;
        for (int c = 0; c < 7; c++) begin
            checks++;
            if (gate_ena !== (c < 4 ? 8'h05 : 8'h00) || res_vld !== 1'b0 || res_idx !== 16'd1) begin
                errs++;
                $display("FAIL bp_gate c%0d gate=%h vld=%b idx=%0d", c, gate_ena, res_vld, res_idx);
            end
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (res_vld !== 1'b1 || res_idx !== 16'd1 || gate_ena !== 8'h00) begin
                errs++;
                $display("FAIL bp_hold k%0d vld=%b idx=%0d gate=%h, want 1 1 00", k, res_vld, res_idx, gate_ena);
            end
            if (k == 9) res_rdy = 1'b1;
            tick();
        end
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (res_vld !== 1'b0 || gate_ena !== 8'h00 || res_idx !== 16'd2) begin
                errs++;
                $display("FAIL bp_gap c%0d vld=%b gate=%h idx=%0d, want 0 00 2", c, res_vld, gate_ena, res_idx);
            end
            tick();
        end
        checks++;
        if (gate_ena !== 8'h05 || res_idx !== 16'd2) begin
            errs++;
            $display("FAIL bp_next_gate gate=%h idx=%0d, want 05 2", gate_ena, res_idx);
        end
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic test_corners();
        cfg_mask = 8'hA0; cfg_gate = 0; cfg_gap = 0; cfg_nrep = 2; res_rdy = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (gate_ena !== 8'hA0 || busy !== 1'b1) begin errs++; $display("FAIL g0_open gate=%h busy=%b, want A0 1", gate_ena, busy); end
        tick();
        checks++;
        if (gate_ena !== 8'h00) begin errs++; $display("FAIL g0_one_cycle gate=%h, want 00", gate_ena); end
        repeat (3) tick();
        checks++;
        if (res_vld !== 1'b1 || res_idx !== 16'd0) begin errs++; $display("FAIL p0_hold vld=%b idx=%0d, want 1 0", res_vld, res_idx); end
        tick();
        checks++;
        if (gate_ena !== 8'hA0 || res_idx !== 16'd1 || res_vld !== 1'b0) begin
            errs++;
            $display("FAIL p0_next_gate gate=%h idx=%0d vld=%b, want A0 1 0", gate_ena, res_idx, res_vld);
        end
        tick();
        checks++;
        if (gate_ena !== 8'h00) begin errs++; $display("FAIL p0_gate_close gate=%h, want 00", gate_ena); end
        repeat (3) tick();
        checks++;
        if (res_vld !== 1'b1 || res_idx !== 16'd1) begin errs++; $display("FAIL p0_hold2 vld=%b idx=%0d, want 1 1", res_vld, res_idx); end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL p0_done done=%b busy=%b, want 1 0", done, busy); end
        tick();
        cfg_nrep = 0;
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || gate_ena !== 8'h00) begin
            errs++;
            $display("FAIL nrep0_done done=%b busy=%b gate=%h, want 1 0 00", done, busy, gate_ena);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || gate_ena !== 8'h00) begin
                errs++;
                $display("FAIL nrep0_quiet c%0d done=%b busy=%b gate=%h, want 0 0 00", c, done, busy, gate_ena);
            end
        end
    endtask

    task automatic test_abort();
        cfg_mask = 8'h05; cfg_gate = 4; cfg_gap = 2; cfg_nrep = 3; res_rdy = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        repeat (11) tick();
        checks++;
        if (gate_ena !== 8'h05 || res_idx !== 16'd1) begin errs++; $display("FAIL abort_pre gate=%h idx=%0d, want 05 1", gate_ena, res_idx); end
        abort = 1'b1; tick(); abort = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (gate_ena !== 8'h00 || busy !== 1'b0 || res_vld !== 1'b0 || done !== 1'b0) begin
                errs++;
                $display("FAIL abort_idle c%0d gate=%h busy=%b vld=%b done=%b, want 00 0 0 0", c, gate_ena, busy, res_vld, done);
            end
            tick();
        end
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (gate_ena !== 8'h05 || res_idx !== 16'd0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL abort_restart gate=%h idx=%0d busy=%b, want 05 0 1", gate_ena, res_idx, busy);
        end
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic test_simultaneous();
        cfg_mask = 8'h05; cfg_gate = 2; cfg_gap = 0; cfg_nrep = 1; res_rdy = 1'b1;
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || gate_ena !== 8'h00) begin errs++; $display("FAIL start_abort busy=%b gate=%h, want 0 00", busy, gate_ena); end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL start_abort_late busy=%b done=%b, want 0 0", busy, done); end
        start = 1'b1; tick(); start = 1'b0;
        cfg_mask = 8'hFF; cfg_gate = 10; cfg_nrep = 5;
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (gate_ena !== 8'h05) begin errs++; $display("FAIL busy_start_mask gate=%h, want 05", gate_ena); end
        tick();
        checks++;
        if (gate_ena !== 8'h00) begin errs++; $display("FAIL busy_start_len gate=%h, want 00", gate_ena); end
        repeat (3) tick();
        checks++;
        if (res_vld !== 1'b1 || res_idx !== 16'd0) begin errs++; $display("FAIL busy_start_hold vld=%b idx=%0d, want 1 0", res_vld, res_idx); end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL busy_start_nrep done=%b busy=%b, want 1 0", done, busy); end
        tick();
        cfg_mask = 8'h05; cfg_gate = 1; cfg_nrep = 1; res_rdy = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        checks++;
        if (res_vld !== 1'b1) begin errs++; $display("FAIL rst_pre_hold vld=%b, want 1", res_vld); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if ({gate_ena, busy, res_vld, res_idx, done} !== 27'd0) begin
            errs++;
            $display("FAIL rst_hold gate=%h busy=%b vld=%b idx=%0d done=%b, want all 0", gate_ena, busy, res_vld, res_idx, done);
        end
        res_rdy = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL rst_after done=%b busy=%b, want 0 0", done, busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_pressure();
        test_corners();
        test_abort();
        test_simultaneous();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
